// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - immediate format enum, RV32I opcodes and pipeline entry type
// Optional feature macro: IMM_GEN_ILLEGAL_EN adds the illegal flag to imm_entry_t.
package imm_gen_pkg;

    // Entries always carry the widest supported immediate; the top trims to XLEN.
    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        imm_fmt_e            fmt;
`ifdef IMM_GEN_ILLEGAL_EN
        logic                illegal;
`endif
    } imm_entry_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle
// Signals: in_valid/in_ready/in_instr (instruction side), out_valid/out_ready/
// out_imm/out_fmt (immediate side), out_illegal only with IMM_GEN_ILLEGAL_EN.
// Modports: master = producer/consumer environment, slave = imm_gen_pipe.
interface imm_gen_pipe_if
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    imm_fmt_e        out_fmt;
`ifdef IMM_GEN_ILLEGAL_EN
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal
    );
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal
    );
`else
    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt
    );
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt
    );
`endif
endinterface

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational RV32I instruction -> sign-extended immediate entry
// Ports: i_instr (32-bit instruction word), o_entry (imm_entry_t: imm, fmt[, illegal]).
// With IMM_GEN_ILLEGAL_EN the entry also flags words outside the decode table.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] i_instr,
    output imm_entry_t  o_entry
);

    logic [6:0]      w_opc;
    logic [2:0]      w_funct3;
    logic            w_sign;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm_x;

    assign w_opc    = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_sign   = i_instr[31];

    always_comb begin
        w_imm32       = '0;
        o_entry.fmt   = FMT_NONE;
`ifdef IMM_GEN_ILLEGAL_EN
        // Table opcodes all end in 2'b11, so a miss covers compressed words too.
        o_entry.illegal = 1'b1;
`endif
        case (w_opc)
            OPC_OP_IMM: begin
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    // instr[30] selects srai/srli and is not part of the amount.
                    w_imm32     = {27'b0, i_instr[24:20]};
                    o_entry.fmt = FMT_SHAMT;
                end else begin
                    w_imm32     = {{20{w_sign}}, i_instr[31:20]};
                    o_entry.fmt = FMT_I;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                w_imm32     = {{20{w_sign}}, i_instr[31:20]};
                o_entry.fmt = FMT_I;
            end
            OPC_STORE: begin
                w_imm32     = {{20{w_sign}}, i_instr[31:25], i_instr[11:7]};
                o_entry.fmt = FMT_S;
            end
            OPC_BRANCH: begin
                w_imm32     = {{20{w_sign}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
                o_entry.fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_imm32     = {i_instr[31:12], 12'b0};
                o_entry.fmt = FMT_U;
            end
            OPC_JAL: begin
                w_imm32     = {{12{w_sign}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
                o_entry.fmt = FMT_J;
            end
            default: begin
                w_imm32     = '0;
                o_entry.fmt = FMT_NONE;
            end
        endcase
`ifdef IMM_GEN_ILLEGAL_EN
        if (o_entry.fmt != FMT_NONE) begin
            o_entry.illegal = 1'b0;
        end
`endif
    end

    // Bit 31 of w_imm32 is instr[31] for every signed format and 0 for SHAMT/NONE,
    // so a plain signed widening gives the required extension.
    assign w_imm_x     = XLEN'($signed(w_imm32));
    assign o_entry.imm = XLEN_MAX'($signed(w_imm_x));

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator behind a 2-entry skid buffer
// Ports: clk, rst_n (async active-low), flush (sync discard), bus (imm_gen_pipe_if.slave:
// in_valid/in_ready/in_instr, out_valid/out_ready/out_imm/out_fmt[/out_illegal]).
// Optional feature macro: IMM_GEN_ILLEGAL_EN (out_illegal carried with each entry).
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    imm_entry_t w_dec;
    imm_entry_t r_out;
    imm_entry_t r_skid;
    logic       r_out_valid;
    logic       r_skid_valid;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_out_free;
    logic       w_unused_imm;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .i_instr (bus.in_instr),
        .o_entry (w_dec)
    );

    // Registered state only (plus reset gating) so in_ready never depends on out_ready.
    assign w_in_ready = rst_n && !r_skid_valid;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_free = !r_out_valid || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out        <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            // Valid bits only; stale data is harmless once invalidated.
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // in_ready was low this cycle, so no new word competes with the skid.
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out       <= w_dec;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_imm   = r_out.imm[XLEN-1:0];
    assign bus.out_fmt   = r_out.fmt;
`ifdef IMM_GEN_ILLEGAL_EN
    assign bus.out_illegal = r_out.illegal;
`endif

    // Immediate bits above XLEN are dropped at the output.
    assign w_unused_imm = ^r_out.imm;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed table and handshake sequences for imm_gen_pipe
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_checks;
    int   n_fail;
    vec_t vecs[14];

    imm_gen_pipe_if #(.XLEN(XLEN)) u_if ();

    imm_gen_pipe #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [31:0] imm, input logic [2:0] fmt);
        check({name, " valid"}, {63'b0, u_if.out_valid}, 64'd1);
        check({name, " imm"}, {32'b0, u_if.out_imm}, {32'b0, imm});
        check({name, " fmt"}, {61'b0, u_if.out_fmt}, {61'b0, fmt});
    endtask

    task automatic drive(input logic v, input logic [31:0] instr);
        u_if.in_valid = v;
        u_if.in_instr = instr;
    endtask

    localparam logic [31:0] A_INSTR = 32'hFFF00093;
    localparam logic [31:0] B_INSTR = 32'h123452B7;
    localparam logic [31:0] C_INSTR = 32'h001000EF;
    localparam logic [31:0] D_INSTR = 32'hFE112E23;

    task automatic fill_two(input logic [31:0] first, input logic [31:0] second);
        u_if.out_ready = 1'b0;
        drive(1'b1, first);
        @(negedge clk);
        drive(1'b1, second);
        @(negedge clk);
        drive(1'b0, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0};
        vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0};
        vecs[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0};
        vecs[3]  = '{32'h001000EF, 32'h00000800, 3'd5, 1'b0};
        vecs[4]  = '{32'h123452B7, 32'h12345000, 3'd4, 1'b0};
        vecs[5]  = '{32'h4030D093, 32'h00000003, 3'd6, 1'b0};
        vecs[6]  = '{32'h002081B3, 32'h00000000, 3'd0, 1'b1};
        vecs[7]  = '{32'h00812083, 32'h00000008, 3'd1, 1'b0};
        vecs[8]  = '{32'hFFC08067, 32'hFFFFFFFC, 3'd1, 1'b0};
        vecs[9]  = '{32'hFFFFF117, 32'hFFFFF000, 3'd4, 1'b0};
        vecs[10] = '{32'h00509093, 32'h00000005, 3'd6, 1'b0};
        vecs[11] = '{32'h00000000, 32'h00000000, 3'd0, 1'b1};
        vecs[12] = '{32'h00000013, 32'h00000000, 3'd1, 1'b0};
        vecs[13] = '{32'h7FF00093, 32'h000007FF, 3'd1, 1'b0};

        rst_n          = 1'b0;
        flush          = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.in_instr  = 32'h0;
        u_if.out_ready = 1'b1;

        // Reset state, with an input offered to confirm it is refused.
        drive(1'b1, A_INSTR);
        repeat (3) @(negedge clk);
        check("rst in_ready", {63'b0, u_if.in_ready}, 64'd0);
        check("rst out_valid", {63'b0, u_if.out_valid}, 64'd0);
        check("rst out_imm", {32'b0, u_if.out_imm}, 64'd0);
        check("rst out_fmt", {61'b0, u_if.out_fmt}, 64'd0);
`ifdef IMM_GEN_ILLEGAL_EN
        check("rst out_illegal", {63'b0, u_if.out_illegal}, 64'd0);
`endif
        drive(1'b0, 32'h0);
        rst_n = 1'b1;
        #1;
        check("post-rst in_ready", {63'b0, u_if.in_ready}, 64'd1);

        // Streamed table at one word per cycle; each result must appear next cycle.
        for (int i = 0; i <= 14; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check_out($sformatf("vec%0d", i - 1), vecs[i-1].imm, vecs[i-1].fmt);
`ifdef IMM_GEN_ILLEGAL_EN
                check($sformatf("vec%0d illegal", i - 1), {63'b0, u_if.out_illegal},
                      {63'b0, vecs[i-1].ill});
`endif
                check($sformatf("vec%0d in_ready", i - 1), {63'b0, u_if.in_ready}, 64'd1);
            end
            if (i < 14) drive(1'b1, vecs[i].instr);
            else        drive(1'b0, 32'h0);
        end
        @(negedge clk);
        check("drained out_valid", {63'b0, u_if.out_valid}, 64'd0);

        // Backpressure: A held, B in skid, C stalls; release gives A, B, C back to back.
        u_if.out_ready = 1'b0;
        drive(1'b1, A_INSTR);
        @(negedge clk);
        check_out("bp A first", 32'hFFFFFFFF, 3'd1);
        check("bp in_ready 1", {63'b0, u_if.in_ready}, 64'd1);
        drive(1'b1, B_INSTR);
        @(negedge clk);
        check_out("bp A held", 32'hFFFFFFFF, 3'd1);
        check("bp skid full", {63'b0, u_if.in_ready}, 64'd0);
        drive(1'b1, C_INSTR);
        @(negedge clk);
        check_out("bp A stable", 32'hFFFFFFFF, 3'd1);
        check("bp C stalled", {63'b0, u_if.in_ready}, 64'd0);
        u_if.out_ready = 1'b1;
        @(negedge clk);
        check_out("bp B out", 32'h12345000, 3'd4);
        check("bp in_ready back", {63'b0, u_if.in_ready}, 64'd1);
        @(negedge clk);
        check_out("bp C out", 32'h00000800, 3'd5);
        drive(1'b0, 32'h0);
        @(negedge clk);
        check("bp no dup", {63'b0, u_if.out_valid}, 64'd0);

        // Flush with skid full and a word offered.
        fill_two(A_INSTR, B_INSTR);
        flush = 1'b1;
        drive(1'b1, C_INSTR);
        @(negedge clk);
        check("flush full out_valid", {63'b0, u_if.out_valid}, 64'd0);
        check("flush full in_ready", {63'b0, u_if.in_ready}, 64'd1);
        flush = 1'b0;
        drive(1'b0, 32'h0);
        u_if.out_ready = 1'b1;
        @(negedge clk);
        check("flush full dropped", {63'b0, u_if.out_valid}, 64'd0);

        // Flush while in_ready=1: the offered word must still be dropped.
        u_if.out_ready = 1'b0;
        drive(1'b1, A_INSTR);
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, D_INSTR);
        @(negedge clk);
        check("flush prio out_valid", {63'b0, u_if.out_valid}, 64'd0);
        flush = 1'b0;
        drive(1'b0, 32'h0);
        @(negedge clk);
        check("flush prio dropped", {63'b0, u_if.out_valid}, 64'd0);
        check("flush prio in_ready", {63'b0, u_if.in_ready}, 64'd1);

        // Reset pulse mid-stall discards both entries.
        fill_two(D_INSTR, B_INSTR);
        check("pre-rst skid full", {63'b0, u_if.in_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", {63'b0, u_if.out_valid}, 64'd0);
        check("midrst in_ready", {63'b0, u_if.in_ready}, 64'd0);
        check("midrst out_imm", {32'b0, u_if.out_imm}, 64'd0);
        check("midrst out_fmt", {61'b0, u_if.out_fmt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        u_if.out_ready = 1'b1;
        @(negedge clk);
        check("after midrst out_valid", {63'b0, u_if.out_valid}, 64'd0);
        check("after midrst in_ready", {63'b0, u_if.in_ready}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
